led_color_fader: RTL and testbench

- Parametrised successor to the team's 24-bit LED colour helpers; moves colour generation from combinational functions into a clocked engine.
- Accepts a fade command (start colour, end colour, step count, step period) and emits a stream of interpolated RGB colours to the LED driver over a valid/ready interface.
- Sits between the LED control register block (command source) and the PWM/serial LED driver (sink).

---
 rtl/led_color_fader_if.sv | 30 +++
 rtl/led_color_fader.sv | 138 +++++++++++++
 tb/tb_led_color_fader.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/led_color_fader_if.sv
// Command and colour-stream bundle for led_color_fader.
// master: register block / LED driver side; slave: the fader.
interface led_color_fader_if #(
    parameter int CH_WIDTH     = 8,
    parameter int MAX_SHIFT    = 8,
    parameter int PERIOD_WIDTH = 16
);
    logic                             cmd_valid;
    logic                             cmd_ready;
    logic [3*CH_WIDTH-1:0]            cmd_start;
    logic [3*CH_WIDTH-1:0]            cmd_end;
    logic [$clog2(MAX_SHIFT+1)-1:0]   cmd_shift;
    logic [PERIOD_WIDTH-1:0]          cmd_period;
    logic                             out_valid;
    logic                             out_ready;
    logic [3*CH_WIDTH-1:0]            out_color;
    logic                             out_last;

    modport master (
        output cmd_valid, cmd_start, cmd_end, cmd_shift, cmd_period,
        output out_ready,
        input  cmd_ready, out_valid, out_color, out_last
    );

    modport slave (
        input  cmd_valid, cmd_start, cmd_end, cmd_shift, cmd_period,
        input  out_ready,
        output cmd_ready, out_valid, out_color, out_last
    );
endinterface

// File: rtl/led_color_fader.sv
// Clocked RGB fade engine: linear interpolation over 2^shift steps.
// Optional LED_FADE_ABORT_EN adds an abort input that cancels a fade.
module led_color_fader #(
    parameter int CH_WIDTH     = 8,
    parameter int MAX_SHIFT    = 8,
    parameter int PERIOD_WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
`ifdef LED_FADE_ABORT_EN
    input  logic              abort,
`endif
    led_color_fader_if.slave  fade,
    output logic              busy
);
    localparam int CW    = 3 * CH_WIDTH;
    localparam int SW    = $clog2(MAX_SHIFT + 1);
    localparam int KW    = MAX_SHIFT + 1;
    localparam int PRODW = CH_WIDTH + MAX_SHIFT + 2;

    typedef enum logic [1:0] {IDLE, EMIT, WAIT} state_t;

    state_t                  state, state_n;
    logic [CW-1:0]           start_q, end_q, color_n, color_q;
    logic [SW-1:0]           s_q, s_cmd;
    logic [PERIOD_WIDTH-1:0] period_q, cnt, cnt_n;
    logic [KW-1:0]           k, k_n, k_full;
    logic                    last_q, accept, hs, done, stop;

`ifdef LED_FADE_ABORT_EN
    assign stop = abort;
`else
    assign stop = 1'b0;
`endif

    assign fade.cmd_ready = (state == IDLE);
    assign fade.out_valid = (state == EMIT);
    assign fade.out_color = color_q;
    assign fade.out_last  = last_q;
    assign busy           = (state != IDLE);

    assign accept = fade.cmd_valid & fade.cmd_ready;
    assign hs     = fade.out_valid & fade.out_ready;
    assign k_full = KW'(1) << s_q;
    assign done   = (k == k_full);
    assign s_cmd  = (fade.cmd_shift > SW'(MAX_SHIFT)) ?
                    SW'(MAX_SHIFT) : fade.cmd_shift;

    always_comb begin
        state_n = state;
        k_n     = k;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = EMIT;
                    k_n     = '0;
                end
            end
            EMIT: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (hs) begin
                    if (done) begin
                        state_n = IDLE;
                    end else begin
                        k_n = k + 1'b1;
                        // period 0 and 1 both mean back-to-back samples
                        if (period_q > PERIOD_WIDTH'(1)) begin
                            state_n = WAIT;
                            cnt_n   = period_q;
                        end
                    end
                end
            end
            WAIT: begin
                if (stop) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                    if (cnt <= PERIOD_WIDTH'(2)) state_n = EMIT;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            k     <= k_n;
            cnt   <= cnt_n;
        end
    end

    // Per channel: start + floor(delta * k / 2^s), k being the next sample.
    for (genvar c = 0; c < 3; c++) begin : g_ch
        logic [CH_WIDTH-1:0]     a, b;
        logic signed [CH_WIDTH:0] delta;
        logic signed [PRODW-1:0] dx, kx, prod;

        assign a     = start_q[c*CH_WIDTH +: CH_WIDTH];
        assign b     = end_q[c*CH_WIDTH +: CH_WIDTH];
        assign delta = $signed({1'b0, b}) - $signed({1'b0, a});
        assign dx    = PRODW'(delta);
        assign kx    = PRODW'({1'b0, k_n});
        assign prod  = dx * kx;
        assign color_n[c*CH_WIDTH +: CH_WIDTH] =
            a + CH_WIDTH'(prod >>> s_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q  <= '0;
            end_q    <= '0;
            s_q      <= '0;
            period_q <= '0;
            color_q  <= '0;
            last_q   <= 1'b0;
        end else if (accept) begin
            start_q  <= fade.cmd_start;
            end_q    <= fade.cmd_end;
            s_q      <= s_cmd;
            period_q <= fade.cmd_period;
            color_q  <= fade.cmd_start;
            last_q   <= 1'b0;
        end else if (state_n == EMIT && (state != EMIT || hs)) begin
            color_q <= color_n;
            last_q  <= (k_n == k_full);
        end else if (state_n == IDLE) begin
            last_q  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_led_color_fader.sv
// Directed bench for led_color_fader.
// Expected colours are hand-computed constants.
module tb_led_color_fader;
    localparam int CW = 8;
    localparam int MS = 8;
    localparam int PW = 16;

    logic clk = 1'b0;
    logic rst;
    logic busy;
`ifdef LED_FADE_ABORT_EN
    logic abort;
`endif
    int checks = 0;
    int errors = 0;

    led_color_fader_if #(
        .CH_WIDTH(CW), .MAX_SHIFT(MS), .PERIOD_WIDTH(PW)
    ) fade ();

    led_color_fader #(
        .CH_WIDTH(CW), .MAX_SHIFT(MS), .PERIOD_WIDTH(PW)
    ) dut (
        .clk  (clk),
        .rst  (rst),
`ifdef LED_FADE_ABORT_EN
        .abort(abort),
`endif
        .fade (fade),
        .busy (busy)
    );

    always #5 clk = ~clk;

    logic [23:0] rise[5] = '{24'h000000, 24'h3F2000, 24'h7F4000,
                             24'hBF6000, 24'hFF8000};
    logic [23:0] fall[5] = '{24'h0A0000, 24'h070000, 24'h050000,
                             24'h020000, 24'h000000};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [23:0] s, input logic [23:0] e,
                        input logic [3:0] sh, input logic [15:0] p);
        fade.cmd_start  = s;
        fade.cmd_end    = e;
        fade.cmd_shift  = sh;
        fade.cmd_period = p;
        fade.cmd_valid  = 1'b1;
        tick();
        fade.cmd_valid  = 1'b0;
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_valid"}, 32'(fade.out_valid), 0);
        chk({tag, "_ready"}, 32'(fade.cmd_ready), 1);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        int n, lasts;
        rst = 1'b1;
        fade.cmd_valid  = 1'b0;
        fade.cmd_start  = '0;
        fade.cmd_end    = '0;
        fade.cmd_shift  = '0;
        fade.cmd_period = '0;
        fade.out_ready  = 1'b0;
`ifdef LED_FADE_ABORT_EN
        abort = 1'b0;
`endif
        tick();
        tick();
        idle_chk("rst");
        chk("rst_color", 32'(fade.out_color), 0);
        chk("rst_last", 32'(fade.out_last), 0);
        rst = 1'b0;
        fade.out_ready = 1'b1;
        tick();
        idle_chk("ready_idle");

        // rising fade
        send(24'h000000, 24'hFF8000, 4'd2, 16'd0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rise_valid%0d", i), 32'(fade.out_valid), 1);
            chk($sformatf("rise_col%0d", i), 32'(fade.out_color),
                32'(rise[i]));
            chk($sformatf("rise_last%0d", i), 32'(fade.out_last),
                32'(i == 4));
            tick();
        end
        idle_chk("rise_end");

        // falling, inexact division
        send(24'h0A0000, 24'h000000, 4'd2, 16'd0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("fall_col%0d", i), 32'(fade.out_color),
                32'(fall[i]));
            tick();
        end
        idle_chk("fall_end");

        // pacing with period 3 and a 4-cycle stall on sample 1
        send(24'h000000, 24'h0000FF, 4'd1, 16'd3);
        chk("pace_col0", 32'(fade.out_color), 32'h000000);
        tick();
        fade.out_ready = 1'b0;
        chk("pace_gap0a", 32'(fade.out_valid), 0);
        tick();
        chk("pace_gap0b", 32'(fade.out_valid), 0);
        tick();
        chk("pace_valid1", 32'(fade.out_valid), 1);
        fade.cmd_valid = 1'b1;
        fade.cmd_start = 24'h555555;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("stall_col%0d", i), 32'(fade.out_color),
                32'h00007F);
            chk($sformatf("stall_valid%0d", i), 32'(fade.out_valid), 1);
            chk($sformatf("busy_ready%0d", i), 32'(fade.cmd_ready), 0);
            if (i < 3) tick();
        end
        fade.cmd_valid = 1'b0;
        fade.out_ready = 1'b1;
        tick();
        chk("pace_gap1a", 32'(fade.out_valid), 0);
        tick();
        chk("pace_gap1b", 32'(fade.out_valid), 0);
        tick();
        chk("pace_col2", 32'(fade.out_color), 32'h0000FF);
        chk("pace_last2", 32'(fade.out_last), 1);
        tick();
        idle_chk("pace_end");

        // s = 0
        send(24'h123456, 24'h654321, 4'd0, 16'd0);
        chk("s0_col0", 32'(fade.out_color), 32'h123456);
        chk("s0_last0", 32'(fade.out_last), 0);
        tick();
        chk("s0_col1", 32'(fade.out_color), 32'h654321);
        chk("s0_last1", 32'(fade.out_last), 1);
        tick();
        idle_chk("s0_end");

        // clamp: shift 15 -> 256 steps, 257 samples
        send(24'h000000, 24'hFFFFFF, 4'd15, 16'd0);
        n = 0;
        lasts = 0;
        for (int cyc = 0; cyc < 600 && fade.out_valid; cyc++) begin
            if (n == 0)
                chk("clamp_first", 32'(fade.out_color), 32'h000000);
            if (n == 128)
                chk("clamp_mid", 32'(fade.out_color), 32'h7F7F7F);
            if (n == 256)
                chk("clamp_final", 32'(fade.out_color), 32'hFFFFFF);
            if (fade.out_last) lasts += (n == 256) ? 1 : 100;
            n++;
            tick();
        end
        chk("clamp_count", 32'(n), 257);
        chk("clamp_lastflag", 32'(lasts), 1);
        idle_chk("clamp_end");

        // reset mid-fade, then a fresh start==end fade
        send(24'h102030, 24'hF0E0D0, 4'd3, 16'd5);
        tick();
        chk("rmid_busy", 32'(busy), 1);
        chk("rmid_wait", 32'(fade.out_valid), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_chk("rmid");
        chk("rmid_color", 32'(fade.out_color), 0);
        send(24'hABCDEF, 24'hABCDEF, 4'd1, 16'd0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("same_col%0d", i), 32'(fade.out_color),
                32'hABCDEF);
            chk($sformatf("same_valid%0d", i), 32'(fade.out_valid), 1);
            tick();
        end
        idle_chk("same_end");

`ifdef LED_FADE_ABORT_EN
        send(24'h000000, 24'h0000FF, 4'd3, 16'd0);
        tick();
        tick();
        fade.out_ready = 1'b0;
        chk("ab_col2", 32'(fade.out_color), 32'h00003F);
        tick();
        chk("ab_hold", 32'(fade.out_color), 32'h00003F);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        idle_chk("ab");
        chk("ab_last", 32'(fade.out_last), 0);
        abort = 1'b1;
        fade.out_ready = 1'b1;
        send(24'h112233, 24'h445566, 4'd0, 16'd0);
        abort = 1'b0;
        chk("ab_accept", 32'(fade.out_valid), 1);
        chk("ab_newcol", 32'(fade.out_color), 32'h112233);
        tick();
        chk("ab_newend", 32'(fade.out_color), 32'h445566);
        tick();
        idle_chk("ab_end");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
